// File: rtl/led_pwm_sequencer_if.sv
// rtl/led_pwm_sequencer_if.sv - control PIO to LED sequencer signal bundle
interface led_pwm_sequencer_if #(
    parameter int WIDTH    = 18,
    parameter int PWM_BITS = 4
);
    logic [WIDTH-1:0]    led_data;
    logic [1:0]          mode;
    logic [PWM_BITS-1:0] duty;
    logic [WIDTH-1:0]    led_out;
    logic                frame_tick;

    modport master (
        output led_data,
        output mode,
        output duty,
        input  led_out,
        input  frame_tick
    );

    modport slave (
        input  led_data,
        input  mode,
        input  duty,
        output led_out,
        output frame_tick
    );
endinterface

// File: rtl/led_pwm_sequencer.sv
// rtl/led_pwm_sequencer.sv - LED PWM brightness with blink, chase and alternate effects
module led_pwm_sequencer #(
    parameter int WIDTH    = 18,
    parameter int PWM_BITS = 4,
    parameter int CLK_HZ   = 50000000,
    parameter int BLINK_HZ = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    led_pwm_sequencer_if.slave   bus
);
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int DIV_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_CHASE  = 2'b10,
        MODE_ALT    = 2'b11
    } mode_t;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [DIV_W-1:0]    div_cnt;
    logic                phase;
    logic [WIDTH-1:0]    data_s;
    mode_t               mode_s;
    logic [PWM_BITS-1:0] duty_s;
    logic [WIDTH-1:0]    rot;
    logic [WIDTH-1:0]    led_out_r;
    logic                frame_tick_r;

    logic                boundary;
    logic                step;
    logic                pwm_on;
    logic                reload;
    mode_t               mode_next;
    logic [WIDTH-1:0]    pattern;

    assign mode_next = mode_t'(bus.mode);
    assign boundary  = (pwm_cnt == {PWM_BITS{1'b1}});
    assign step      = (div_cnt == DIV_MAX);
    assign pwm_on    = (duty_s == {PWM_BITS{1'b1}}) ? 1'b1 : (pwm_cnt < duty_s);

    // Reload only when chase is entered or its seed changes, so a steady seed keeps rotating.
    assign reload = boundary && (mode_next == MODE_CHASE) &&
                    ((mode_s != MODE_CHASE) || (bus.led_data != data_s));

    always_comb begin
        pattern = data_s;
        case (mode_s)
            MODE_STATIC: pattern = data_s;
            MODE_BLINK:  pattern = phase ? data_s : '0;
            MODE_CHASE:  pattern = rot;
            MODE_ALT:    pattern = phase ? data_s : ~data_s;
            default:     pattern = data_s;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt      <= '0;
            div_cnt      <= '0;
            phase        <= 1'b0;
            data_s       <= '0;
            mode_s       <= MODE_STATIC;
            duty_s       <= '0;
            rot          <= '0;
            led_out_r    <= '0;
            frame_tick_r <= 1'b0;
        end else begin
            pwm_cnt      <= pwm_cnt + 1'b1;
            frame_tick_r <= boundary;
            div_cnt      <= step ? '0 : div_cnt + 1'b1;
            if (step) begin
                phase <= ~phase;
            end
            // Shadow registers change only at a period wrap so effects never tear mid-period.
            if (boundary) begin
                data_s <= bus.led_data;
                mode_s <= mode_next;
                duty_s <= bus.duty;
            end
            if (reload) begin
                rot <= bus.led_data;
            end else if (step && (mode_s == MODE_CHASE)) begin
                rot <= {rot[WIDTH-2:0], rot[WIDTH-1]};
            end
            led_out_r <= pattern & {WIDTH{pwm_on}};
        end
    end

    assign bus.led_out    = led_out_r;
    assign bus.frame_tick = frame_tick_r;
endmodule
